// File: rtl/sonar_array_ctrl.sv
// sonar_array_ctrl: sequential multi-channel ultrasonic ranger; define SONAR_MIN_TRACK_EN to add min_distance/min_ch
module sonar_array_ctrl #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int N_CH = 4,
  parameter int DIST_W = 9,
  parameter int TRIG_US = 11,
  parameter int US_PER_CM = 58,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic continuous,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH-1:0] echo,
  output logic [N_CH-1:0] trig,
  output logic busy,
  output logic done,
  output logic [N_CH*DIST_W-1:0] distance,
  output logic [N_CH-1:0] timeout_flag
`ifdef SONAR_MIN_TRACK_EN
  ,
  output logic [DIST_W-1:0] min_distance,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] min_ch
`endif
);
  localparam int DIV = CLK_FREQ_HZ / 1000000;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CMAX = (TRIG_US > GAP_US) ? TRIG_US : GAP_US;
  localparam int CW = $clog2(CMAX + 1);
  localparam int UW = $clog2(TIMEOUT_US + 1);
  localparam int SW = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  typedef enum logic [2:0] {IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, STORE, GAP, FINISH} state_t;
  state_t state_q;
  logic [N_CH-1:0] s1_q, s2_q, prev_q, mask_q, trig_q, tof_q;
  logic [N_CH*DIST_W-1:0] dist_q;
  logic [PW-1:0] pre_q;
  logic [CW-1:0] cnt_q;
  logic [UW-1:0] us_q;
  logic [SW-1:0] sub_q, sub_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic [CHW-1:0] ch_q, sel_idx;
  logic busy_q, done_q, to_q, sel_found, tick, echo_hi, rise, fall, cnt_tick, sub_wrap, to_hit;
  assign trig = trig_q;
  assign busy = busy_q;
  assign done = done_q;
  assign distance = dist_q;
  assign timeout_flag = tof_q;
  assign tick = pre_q == PW'(DIV - 1);
  assign echo_hi = s2_q[ch_q];
  assign rise = echo_hi & ~prev_q[ch_q];
  assign fall = ~echo_hi & prev_q[ch_q];
  assign cnt_tick = tick & echo_hi & ((state_q == MEASURE) | ((state_q == WAIT_RISE) & rise));
  assign sub_wrap = sub_q == SW'(US_PER_CM - 1);
  assign sub_d = cnt_tick ? (sub_wrap ? '0 : sub_q + 1'b1) : sub_q;
  assign cm_d = (cnt_tick && sub_wrap && !(&cm_q)) ? cm_q + 1'b1 : cm_q;
  assign to_hit = tick && (us_q == UW'(TIMEOUT_US - 1));
  // Lowest-index pending channel of the latched mask
  always_comb begin
    sel_found = 1'b0;
    sel_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel_found = 1'b1;
        sel_idx = CHW'(i);
      end
    end
  end
  // Two-flop echo synchronizer plus previous sample for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      prev_q <= '0;
    end else begin
      s1_q <= echo;
      s2_q <= s1_q;
      prev_q <= s2_q;
    end
  end
  // 1 us tick prescaler, realigned on entry to TRIG and GAP so both last whole ticks
  always_ff @(posedge clk) begin
    pre_q <= (rst || state_q == SELECT || state_q == STORE || tick) ? '0 : pre_q + 1'b1;
  end
  // Sweep sequencer: trigger, wait for echo, measure, store, guard gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      trig_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dist_q <= '0;
      tof_q <= '0;
      mask_q <= '0;
      ch_q <= '0;
      cnt_q <= '0;
      us_q <= '0;
      sub_q <= '0;
      cm_q <= '0;
      to_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= init;
          if (init) begin
            mask_q <= ch_mask;
            state_q <= SELECT;
          end
        end
        SELECT: begin
          if (sel_found) begin
            ch_q <= sel_idx;
            mask_q[sel_idx] <= 1'b0;
            trig_q <= N_CH'(1) << sel_idx;
            cnt_q <= '0;
            state_q <= TRIG;
          end else begin
            state_q <= FINISH;
          end
        end
        TRIG: begin
          if (tick) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(TRIG_US - 1)) begin
              trig_q <= '0;
              us_q <= '0;
              sub_q <= '0;
              cm_q <= '0;
              to_q <= 1'b0;
              state_q <= WAIT_RISE;
            end
          end
        end
        WAIT_RISE: begin
          us_q <= us_q + UW'(tick);
          sub_q <= sub_d;
          cm_q <= cm_d;
          if (to_hit) begin
            to_q <= 1'b1;
            state_q <= STORE;
          end else if (rise) begin
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          us_q <= us_q + UW'(tick);
          sub_q <= sub_d;
          cm_q <= cm_d;
          if (fall) begin
            state_q <= STORE;
          end else if (to_hit) begin
            to_q <= 1'b1;
            state_q <= STORE;
          end
        end
        STORE: begin
          dist_q[ch_q*DIST_W +: DIST_W] <= to_q ? '1 : cm_q;
          tof_q[ch_q] <= to_q;
          cnt_q <= '0;
          state_q <= GAP;
        end
        GAP: begin
          if (tick) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(GAP_US - 1)) state_q <= SELECT;
          end
        end
        FINISH: begin
          done_q <= 1'b1;
          if (continuous) begin
            mask_q <= ch_mask;
            state_q <= SELECT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef SONAR_MIN_TRACK_EN
  logic [DIST_W-1:0] run_min_q, min_dist_q;
  logic [CHW-1:0] run_ch_q, min_ch_q;
  logic found_q;
  assign min_distance = min_dist_q;
  assign min_ch = min_ch_q;
  // Running minimum over valid results of the sweep, published at FINISH
  always_ff @(posedge clk) begin
    if (rst) begin
      run_min_q <= '1;
      run_ch_q <= '0;
      found_q <= 1'b0;
      min_dist_q <= '1;
      min_ch_q <= '0;
    end else begin
      if ((state_q == IDLE && init) || (state_q == FINISH && continuous)) begin
        run_min_q <= '1;
        run_ch_q <= '0;
        found_q <= 1'b0;
      end else if (state_q == STORE && !to_q && (!found_q || cm_q < run_min_q)) begin
        run_min_q <= cm_q;
        run_ch_q <= ch_q;
        found_q <= 1'b1;
      end
      if (state_q == FINISH) begin
        min_dist_q <= found_q ? run_min_q : '1;
        min_ch_q <= found_q ? run_ch_q : '0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_sonar_array_ctrl.sv
// tb_sonar_array_ctrl: scoreboard bench for sonar_array_ctrl at DIV=10, TIMEOUT_US=2000, GAP_US=50
module tb_sonar_array_ctrl;
  logic clk = 0, rst = 1, init = 0, continuous = 0;
  logic [3:0] ch_mask = 0, echo = 0, trig, timeout_flag;
  logic busy, done;
  logic [35:0] distance;
`ifdef SONAR_MIN_TRACK_EN
  logic [8:0] min_distance;
  logic [1:0] min_ch;
`endif
  typedef struct {logic [35:0] d; logic [3:0] f;} exp_t;
  exp_t sb[$];
  logic [8:0] md[4];
  logic [3:0] mf;
  logic [3:0] trig_prev = 0;
  int checks = 0, errors = 0, cyc = 0, ndone = 0, done_cyc = 0, trig_rises = 0, onehot_viol = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sonar_array_ctrl #(.CLK_FREQ_HZ(10000000), .N_CH(4), .DIST_W(9), .TRIG_US(11), .US_PER_CM(58),
                     .TIMEOUT_US(2000), .GAP_US(50)) dut (
    .clk(clk), .rst(rst), .init(init), .continuous(continuous), .ch_mask(ch_mask), .echo(echo),
    .trig(trig), .busy(busy), .done(done), .distance(distance), .timeout_flag(timeout_flag)
`ifdef SONAR_MIN_TRACK_EN
    , .min_distance(min_distance), .min_ch(min_ch)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < 4; i++) e.d[i*9 +: 9] = md[i];
    e.f = mf;
    sb.push_back(e);
  endtask

  task automatic pulse_init(input logic [3:0] m, output int c0);
    @(negedge clk);
    ch_mask = m;
    init = 1;
    c0 = cyc;
    @(negedge clk);
    init = 0;
  endtask

  task automatic wait_done(input int tgt, input string tag);
    int k = 0;
    while (ndone < tgt && k < 60000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, ndone >= tgt, 1);
  endtask

  task automatic pulse(input int ch, input int hi_us);
    echo[ch] = 1;
    repeat (hi_us * 10) @(negedge clk);
    echo[ch] = 0;
  endtask

  task automatic serve(input int ch, input int hi_us, input bit bg, output int t_rise, output int t_fall);
    int k = 0, w = 0;
    while (!trig[ch] && k < 30000) begin
      @(negedge clk);
      k++;
    end
    t_rise = cyc;
    while (trig[ch] && w < 1000) begin
      w++;
      @(negedge clk);
    end
    t_fall = cyc;
    chk($sformatf("trig_width_ch%0d", ch), w, 110);
    repeat (100) @(negedge clk);
    if (hi_us > 0) begin
      if (bg) fork pulse(ch, hi_us); join_none
      else pulse(ch, hi_us);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      trig_rises += $countones(trig & ~trig_prev);
      trig_prev = trig;
      if ($countones(trig) > 1) onehot_viol++;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("distance", distance, e.d);
          chk("timeout_flag", timeout_flag, e.f);
        end
      end
    end
  end

  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, tr, tf, tr3, tf1, n0, r0;
    for (int i = 0; i < 4; i++) md[i] = 0;
    mf = 0;
    repeat (3) @(negedge clk);
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_distance", distance, 0);
    chk("rst_tflag", timeout_flag, 0);
`ifdef SONAR_MIN_TRACK_EN
    chk("rst_min_distance", min_distance, 511);
    chk("rst_min_ch", min_ch, 0);
`endif
    rst = 0;
    md[0] = 20;
    push_exp();
    n0 = ndone;
    pulse_init(4'b0001, c0);
    chk("a_busy", busy, 1);
    serve(0, 1160, 0, tr, tf);
    wait_done(n0 + 1, "a_done");
    @(negedge clk);
    chk("a_idle", busy, 0);
    repeat (20) @(negedge clk);
    chk("a_one_done", ndone, n0 + 1);
`ifdef SONAR_MIN_TRACK_EN
    md[0] = 30; md[1] = 12; md[2] = 12; md[3] = 511; mf = 4'b1000;
    push_exp();
    n0 = ndone;
    pulse_init(4'b1111, c0);
    serve(0, 1740, 0, tr, tf);
    serve(1, 696, 0, tr, tf);
    serve(2, 696, 0, tr, tf);
    serve(3, 0, 0, tr, tf);
    wait_done(n0 + 1, "m_done");
    chk("m_min_distance", min_distance, 12);
    chk("m_min_ch", min_ch, 1);
`else
    md[1] = 10; md[3] = 511; mf = 4'b1000;
    push_exp();
    n0 = ndone;
    pulse_init(4'b1010, c0);
    serve(1, 580, 0, tr, tf1);
    serve(3, 3000, 1, tr3, tf);
    chk("b_gap", (tr3 - tf1) >= 500, 1);
    wait_done(n0 + 1, "b_done");
    md[0] = 511; mf[0] = 1;
    push_exp();
    n0 = ndone;
    pulse_init(4'b0001, c0);
    serve(0, 0, 0, tr, tf);
    wait_done(n0 + 1, "c_timeout_done");
`endif
    md[0] = 0; mf[0] = 0;
    push_exp();
    n0 = ndone;
    pulse_init(4'b0001, c0);
    serve(0, 57, 0, tr, tf);
    wait_done(n0 + 1, "c_short_done");
    md[0] = 1; md[1] = 2; mf[1:0] = 0;
    repeat (3) push_exp();
    n0 = ndone;
    continuous = 1;
    pulse_init(4'b0011, c0);
    for (int k = 0; k < 3; k++) begin
      serve(0, 60, 0, tr, tf);
      if (k == 1) chk("cont_busy", busy, 1);
      if (k == 2) continuous = 0;
      serve(1, 120, 0, tr, tf);
    end
    wait_done(n0 + 3, "cont_done");
`ifdef SONAR_MIN_TRACK_EN
    chk("cont_min_distance", min_distance, 1);
    chk("cont_min_ch", min_ch, 0);
`endif
    r0 = trig_rises;
    repeat (1500) @(negedge clk);
    chk("cont_ndone", ndone, n0 + 3);
    chk("cont_idle", busy, 0);
    chk("cont_no_trig", trig_rises, r0);
    pulse_init(4'b0100, c0);
    serve(2, 0, 0, tr, tf);
    echo[2] = 1;
    repeat (200) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("r_trig", trig, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_distance", distance, 0);
    chk("r_tflag", timeout_flag, 0);
    rst = 0;
    echo[2] = 0;
    for (int i = 0; i < 4; i++) md[i] = 0;
    mf = 0;
    md[2] = 5;
    push_exp();
    n0 = ndone;
    pulse_init(4'b0100, c0);
    serve(2, 290, 0, tr, tf);
    wait_done(n0 + 1, "r_after_done");
    repeat (5) @(negedge clk);
    push_exp();
    n0 = ndone;
    r0 = trig_rises;
    pulse_init(4'b0000, c0);
    wait_done(n0 + 1, "z_done");
    chk("z_latency", done_cyc - c0, 3);
    chk("z_no_trig", trig_rises, r0);
`ifdef SONAR_MIN_TRACK_EN
    chk("z_min_distance", min_distance, 511);
    chk("z_min_ch", min_ch, 0);
`endif
    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("trig_onehot", onehot_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
